// File: rtl/npu_mm_master.sv
`default_nettype none
// ============================================================================
// Module      : npu_mm_master
// Description : Avalon-MM initiator for the NPU register slave. It writes the
//               weight and input words of a job, then reads the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_mm_master #(
    parameter int READ_LATENCY = 1,
    parameter int W_CACHE      = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    // job command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_w,
    input  logic [31:0]      cmd_x,
    // result port
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    // Avalon-MM initiator
    output logic [1:0]       m_addr,
    output logic [31:0]      m_wdata,
    output logic             m_cs,
    output logic             m_read,
    output logic             m_write,
    input  logic [31:0]      m_rdata,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_W = 3'd1,
        S_WR_X = 3'd2,
        S_RD   = 3'd3,
        S_WAIT = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    localparam logic [2:0] c_last_wait = 3'(READ_LATENCY - 1);

    state_t      r_state;
    logic [31:0] r_w;
    logic [31:0] r_x;
    logic [31:0] r_cache_w;
    logic        r_cache_vld;
    logic [2:0]  r_wait;
    logic        w_hit;

    generate
        if (W_CACHE != 0) begin : g_cache
            assign w_hit = r_cache_vld && (cmd_w == r_cache_w);
        end else begin : g_no_cache
            assign w_hit = 1'b0;
        end
    endgenerate

    // Strobes are set one edge ahead, so the bus shows the action of the state
    // currently held in r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_x         <= '0;
            r_cache_w   <= '0;
            r_cache_vld <= 1'b0;
            r_wait      <= '0;
            cmd_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_data    <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_cs        <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            busy        <= 1'b0;
            job_count   <= '0;
        end else begin
            m_cs    <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_w       <= cmd_w;
                        r_x       <= cmd_x;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        m_cs      <= 1'b1;
                        m_write   <= 1'b1;
                        if (w_hit) begin
                            r_state <= S_WR_X;
                            m_addr  <= 2'd1;
                            m_wdata <= cmd_x;
                        end else begin
                            r_state <= S_WR_W;
                            m_addr  <= 2'd0;
                            m_wdata <= cmd_w;
                        end
                    end
                end
                S_WR_W: begin
                    r_cache_w   <= r_w;
                    r_cache_vld <= 1'b1;
                    r_state     <= S_WR_X;
                    m_cs        <= 1'b1;
                    m_write     <= 1'b1;
                    m_addr      <= 2'd1;
                    m_wdata     <= r_x;
                end
                S_WR_X: begin
                    r_state <= S_RD;
                    m_cs    <= 1'b1;
                    m_read  <= 1'b1;
                    m_addr  <= 2'd2;
                end
                S_RD: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid only in the last latency cycle.
                    if (r_wait == c_last_wait) begin
                        res_data  <= m_rdata;
                        res_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_count <= job_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
